// File: rtl/tt_um_alu_nicolas_orcasitas.sv
// 8-bit accumulator-style ALU tile: A is a loadable register, B is ui_in. The result, flag and
// overflow outputs are registered one clock after their inputs; there is no backpressure.
module tt_um_alu_nicolas_orcasitas (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  op_e         op;
  logic        en_a;
  logic [1:0]  flag_sel;
  logic [7:0]  b;

  logic [7:0]  a_q, a_d;
  logic [13:0] res_q, res_d;
  logic        flag_q, flag_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  add_w;
  logic [13:0] sub_w;
  logic [15:0] mul_w;
  logic [14:0] shl_w;

  logic        unused_inputs;

  assign op       = op_e'(uio_in[2:0]);
  assign en_a     = uio_in[3];
  assign flag_sel = uio_in[5:4];
  assign b        = ui_in;

  assign unused_inputs = &{1'b0, ena, uio_in[7:6]};

  // Widen before the arithmetic so carry, borrow and high product bits are kept.
  assign add_w = {1'b0, a_q} + {1'b0, b};
  assign sub_w = {6'b0, a_q} - {6'b0, b};
  assign mul_w = {8'b0, a_q} * {8'b0, b};
  assign shl_w = {7'b0, a_q} << b[2:0];

  assign a_d = en_a ? ui_in : a_q;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = {5'b0, add_w};
        ovf_d = add_w[8];
      end
      OP_SUB: begin
        res_d = sub_w;
        ovf_d = (a_q < b);
      end
      OP_MUL: begin
        res_d = mul_w[13:0];
        ovf_d = |mul_w[15:14];
      end
      OP_AND: res_d = {6'b0, a_q & b};
      OP_OR:  res_d = {6'b0, a_q | b};
      OP_XOR: res_d = {6'b0, a_q ^ b};
      OP_SHL: begin
        res_d = shl_w[13:0];
        ovf_d = shl_w[14];
      end
      OP_SHR: res_d = {6'b0, a_q >> b[2:0]};
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Comparisons use the pre-edge A, matching the operands the result was built from.
  always_comb begin
    flag_d = 1'b0;
    case (flag_sel)
      2'b00:   flag_d = (res_d == 14'd0);
      2'b01:   flag_d = (a_q == b);
      2'b10:   flag_d = (a_q > b);
      default: flag_d = (a_q < b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      res_q  <= res_d;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign uo_out  = res_q[7:0];
  assign uio_out = {ovf_q, flag_q, res_q[13:8]};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_alu_nicolas_orcasitas.sv
// Directed bench for the ALU tile: stimulus pushes hand-computed expectations into a queue,
// a monitor pops one entry per clock edge and compares the registered outputs.
module tb_tt_um_alu_nicolas_orcasitas;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string       name;
    logic [13:0] res;
    logic        flag;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;

  tt_um_alu_nicolas_orcasitas dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at a negedge and queue what the next posedge must produce.
  task automatic step(input string nm, input logic [2:0] op, input logic [1:0] sel,
                      input logic en, input logic [7:0] ui, input logic [1:0] junk,
                      input logic [13:0] res, input logic flag, input logic ovf);
    exp_t e;
    ui_in  = ui;
    uio_in = {junk, sel, en, op};
    e.name = nm;
    e.res  = res;
    e.flag = flag;
    e.ovf  = ovf;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".res"},  {uio_out[5:0], uo_out}, e.res);
      chk({e.name, ".flag"}, {13'b0, uio_out[6]},    {13'b0, e.flag});
      chk({e.name, ".ovf"},  {13'b0, uio_out[7]},    {13'b0, e.ovf});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = 8'hA5;
    uio_in   = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst.uo_out",  {6'b0, uo_out},  14'h0);
    chk("rst.uio_out", {6'b0, uio_out}, 14'h0);
    chk("uio_oe",      {6'b0, uio_oe},  14'h00C0);

    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    step("rel_zero",  3'b000, 2'b00, 1'b0, 8'd0,   2'b00, 14'd0,    1'b1, 1'b0);
    step("load128",   3'b000, 2'b00, 1'b1, 8'd128, 2'b00, 14'd128,  1'b0, 1'b0);
    step("add",       3'b000, 2'b00, 1'b0, 8'd218, 2'b00, 14'h015A, 1'b0, 1'b1);
    step("sub",       3'b001, 2'b01, 1'b0, 8'd218, 2'b00, 14'h3FA6, 1'b0, 1'b1);
    step("mul",       3'b010, 2'b10, 1'b0, 8'd218, 2'b00, 14'h2D00, 1'b0, 1'b1);
    step("and",       3'b011, 2'b11, 1'b0, 8'd218, 2'b00, 14'h0080, 1'b1, 1'b0);
    step("or",        3'b100, 2'b00, 1'b0, 8'd218, 2'b11, 14'd218,  1'b0, 1'b0);
    step("xor",       3'b101, 2'b00, 1'b0, 8'd218, 2'b10, 14'd90,   1'b0, 1'b0);
    step("shl",       3'b110, 2'b00, 1'b0, 8'd218, 2'b01, 14'h0200, 1'b0, 1'b0);
    step("shr",       3'b111, 2'b00, 1'b0, 8'd218, 2'b11, 14'd32,   1'b0, 1'b0);
    step("and_eq",    3'b011, 2'b01, 1'b0, 8'd128, 2'b00, 14'h0080, 1'b1, 1'b0);
    step("and_zero",  3'b011, 2'b00, 1'b0, 8'h7F,  2'b00, 14'd0,    1'b1, 1'b0);
    step("sub_pos",   3'b001, 2'b10, 1'b0, 8'd100, 2'b00, 14'd28,   1'b1, 1'b0);
    step("load5",     3'b000, 2'b00, 1'b1, 8'd5,   2'b00, 14'd133,  1'b0, 1'b0);
    step("load3_old", 3'b000, 2'b00, 1'b1, 8'd3,   2'b00, 14'd8,    1'b0, 1'b0);
    step("load3_new", 3'b000, 2'b00, 1'b0, 8'd3,   2'b00, 14'd6,    1'b0, 1'b0);
    step("load255",   3'b000, 2'b01, 1'b1, 8'd255, 2'b00, 14'h0102, 1'b0, 1'b1);
    step("shl_ovf",   3'b110, 2'b10, 1'b0, 8'd7,   2'b00, 14'h3F80, 1'b1, 1'b1);
    step("shr_max",   3'b111, 2'b11, 1'b0, 8'h0F,  2'b00, 14'd1,    1'b0, 1'b0);
    step("mul_max",   3'b010, 2'b00, 1'b0, 8'd255, 2'b00, 14'h3E01, 1'b0, 1'b1);
    step("mul_mid",   3'b010, 2'b00, 1'b0, 8'd218, 2'b00, 14'h1926, 1'b0, 1'b1);

    // Reset between edges must clear the outputs without waiting for clk.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.uo_out",  {6'b0, uo_out},  14'h0);
    chk("async_rst.uio_out", {6'b0, uio_out}, 14'h0);
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    step("post_rst",  3'b000, 2'b00, 1'b0, 8'd9,   2'b00, 14'd9,    1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
